// File: rtl/sh4a_regfile_client.sv
// Register-file client: operand fetch over two read ports with bypass, interlock and output skid buffer,
// plus an in-order writeback queue drained onto the single write port. Optional counters: SH4A_RFC_STATS_EN.
module sh4a_regfile_client #(
  parameter int unsigned WB_DEPTH   = 4,
  parameter logic [5:0]  CONST0_IDX = 6'd62,
  parameter logic [5:0]  CONST1_IDX = 6'd63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  op_idx_a,
  input  logic [5:0]  op_idx_b,
  input  logic [3:0]  op_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_tag,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [5:0]  wb_idx,
  input  logic [31:0] wb_data,
  output logic [5:0]  rf_idx_read0,
  output logic [5:0]  rf_idx_read1,
  input  logic [31:0] rf_read0,
  input  logic [31:0] rf_read1,
  output logic [5:0]  rf_idx_write,
  output logic [31:0] rf_reg_write,
  output logic        rf_write_enable
`ifdef SH4A_RFC_STATS_EN
  ,
  output logic [31:0] stat_hazard_stalls,
  output logic [31:0] stat_bypasses,
  output logic [31:0] stat_wb_full_cycles
`endif
);

  localparam int unsigned PW = $clog2(WB_DEPTH);

  function automatic logic is_const(input logic [5:0] idx);
    return (idx == CONST0_IDX) || (idx == CONST1_IDX);
  endfunction

  // Returns {override, value}: constants and same-cycle write data replace the register-file output.
  function automatic logic [32:0] pick_src(input logic [5:0] idx, input logic we,
                                           input logic [5:0] widx, input logic [31:0] wdata);
    if (idx == CONST0_IDX)        return {1'b1, 32'd0};
    else if (idx == CONST1_IDX)   return {1'b1, 32'd1};
    else if (we && idx == widx)   return {1'b1, wdata};
    else                          return {1'b0, 32'd0};
  endfunction

  // Writeback queue
  logic [5:0]    q_idx  [WB_DEPTH];
  logic [31:0]   q_data [WB_DEPTH];
  logic [PW-1:0] q_head, q_tail;
  logic [PW:0]   q_count;
  logic          q_full, wb_push, wb_pop;

  assign q_full          = (q_count == (PW+1)'(WB_DEPTH));
  assign wb_ready        = !q_full;
  assign wb_push         = wb_valid && !q_full && !is_const(wb_idx);
  assign rf_write_enable = (q_count != '0) && !reset;
  assign wb_pop          = rf_write_enable;
  assign rf_idx_write    = q_idx[q_head];
  assign rf_reg_write    = q_data[q_head];

  always_ff @(posedge clk) begin
    if (wb_push) begin
      q_idx[q_tail]  <= wb_idx;
      q_data[q_tail] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      if (wb_push) q_tail <= q_tail + PW'(1);
      if (wb_pop)  q_head <= q_head + PW'(1);
      case ({wb_push, wb_pop})
        2'b10:   q_count <= q_count + (PW+1)'(1);
        2'b01:   q_count <= q_count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Hazard: any queued entry other than the head, which is written (and bypassed) this cycle.
  logic haz_a, haz_b;
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int unsigned i = 1; i < WB_DEPTH; i++) begin
      if (i < 32'(q_count)) begin
        if (q_idx[q_head + PW'(i)] == op_idx_a) haz_a = 1'b1;
        if (q_idx[q_head + PW'(i)] == op_idx_b) haz_b = 1'b1;
      end
    end
    if (is_const(op_idx_a)) haz_a = 1'b0;
    if (is_const(op_idx_b)) haz_b = 1'b0;
  end

  // Read issue and in-flight stage
  logic        inf_valid, inf_ovr_a, inf_ovr_b;
  logic [31:0] inf_val_a, inf_val_b;
  logic [3:0]  inf_tag;
  logic        skid_valid;
  logic [31:0] skid_a, skid_b;
  logic [3:0]  skid_tag;
  logic        accept, out_free;
  logic [32:0] src_a, src_b;
  logic [31:0] res_a, res_b;

  assign rf_idx_read0 = op_idx_a;
  assign rf_idx_read1 = op_idx_b;
  assign src_a        = pick_src(op_idx_a, rf_write_enable, rf_idx_write, rf_reg_write);
  assign src_b        = pick_src(op_idx_b, rf_write_enable, rf_idx_write, rf_reg_write);
  assign out_free     = !out_valid || out_ready;
  assign op_ready     = !skid_valid && !(inf_valid && !out_free) && !haz_a && !haz_b;
  assign accept       = op_valid && op_ready;
  assign res_a        = inf_ovr_a ? inf_val_a : rf_read0;
  assign res_b        = inf_ovr_b ? inf_val_b : rf_read1;

  always_ff @(posedge clk) begin
    if (reset) begin
      inf_valid  <= 1'b0;
      inf_ovr_a  <= 1'b0;
      inf_ovr_b  <= 1'b0;
      inf_val_a  <= '0;
      inf_val_b  <= '0;
      inf_tag    <= '0;
      skid_valid <= 1'b0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_tag   <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_tag    <= '0;
    end else begin
      inf_valid <= accept;
      if (accept) begin
        inf_ovr_a <= src_a[32];
        inf_val_a <= src_a[31:0];
        inf_ovr_b <= src_b[32];
        inf_val_b <= src_b[31:0];
        inf_tag   <= op_tag;
      end
      // Skid entry is older than the in-flight result, so it always goes to the output first.
      if (out_free) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_a      <= skid_a;
          out_b      <= skid_b;
          out_tag    <= skid_tag;
          skid_valid <= inf_valid;
          if (inf_valid) begin
            skid_a   <= res_a;
            skid_b   <= res_b;
            skid_tag <= inf_tag;
          end
        end else if (inf_valid) begin
          out_valid <= 1'b1;
          out_a     <= res_a;
          out_b     <= res_b;
          out_tag   <= inf_tag;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (inf_valid) begin
        skid_valid <= 1'b1;
        skid_a     <= res_a;
        skid_b     <= res_b;
        skid_tag   <= inf_tag;
      end
    end
  end

`ifdef SH4A_RFC_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, c} + 33'(inc);
    return s[32] ? '1 : s[31:0];
  endfunction

  logic byp_a, byp_b;
  assign byp_a = accept && rf_write_enable && !is_const(op_idx_a) && (op_idx_a == rf_idx_write);
  assign byp_b = accept && rf_write_enable && !is_const(op_idx_b) && (op_idx_b == rf_idx_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hazard_stalls  <= '0;
      stat_bypasses       <= '0;
      stat_wb_full_cycles <= '0;
    end else begin
      stat_hazard_stalls  <= sat_add(stat_hazard_stalls, {1'b0, op_valid && !op_ready && (haz_a || haz_b)});
      stat_bypasses       <= sat_add(stat_bypasses, {1'b0, byp_a} + {1'b0, byp_b});
      stat_wb_full_cycles <= sat_add(stat_wb_full_cycles, {1'b0, q_full});
    end
  end
`endif

endmodule

// File: tb/tb_sh4a_regfile_client.sv
// Self-checking bench for sh4a_regfile_client: directed scenarios plus randomized traffic scored against
// an architectural register-file model (writes take effect when accepted, results return in order).
module tb_sh4a_regfile_client;
  localparam int unsigned WB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [5:0]  op_idx_a, op_idx_b;
  logic [3:0]  op_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_tag;
  logic        wb_valid, wb_ready;
  logic [5:0]  wb_idx;
  logic [31:0] wb_data;
  logic [5:0]  rf_idx_read0, rf_idx_read1, rf_idx_write;
  logic [31:0] rf_read0, rf_read1, rf_reg_write;
  logic        rf_write_enable;

  sh4a_regfile_client #(.WB_DEPTH(WB_DEPTH), .CONST0_IDX(6'd62), .CONST1_IDX(6'd63)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_idx_a(op_idx_a), .op_idx_b(op_idx_b), .op_tag(op_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_data(wb_data),
    .rf_idx_read0(rf_idx_read0), .rf_idx_read1(rf_idx_read1), .rf_read0(rf_read0), .rf_read1(rf_read1),
    .rf_idx_write(rf_idx_write), .rf_reg_write(rf_reg_write), .rf_write_enable(rf_write_enable)
  );

  always #5 clk = ~clk;

  // Register file: registered read returning the pre-write value on a same-cycle write.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    rf_read0 <= mem[rf_idx_read0];
    rf_read1 <= mem[rf_idx_read1];
    if (rf_write_enable) mem[rf_idx_write] = rf_reg_write;
  end

  typedef struct { logic [3:0] tag; logic [31:0] a; logic [31:0] b; } res_t;
  typedef struct { logic [5:0] idx; logic [31:0] data; } wb_t;

  logic [31:0] arch [64];
  res_t        exp_q [$];
  wb_t         wbq [$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        last_accept;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] arch_val(input logic [5:0] i);
    if (i == 6'd62) return 32'd0;
    if (i == 6'd63) return 32'd1;
    return arch[i];
  endfunction

  function automatic logic [5:0] pick_idx();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 8) return 6'd62;
    if (r == 9) return 6'd63;
    return 6'(r);
  endfunction

  task automatic idle();
    op_valid = 1'b0; op_idx_a = '0; op_idx_b = '0; op_tag = '0;
    wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
    out_ready = 1'b1;
  endtask

  // Called at a negedge with inputs set: score this cycle, update the model, advance to the next negedge.
  task automatic eval();
    res_t r;
    wb_t  w;
    #1;
    last_accept = 1'b0;
    if (reset) begin
      check_eq("we_in_reset", 32'(rf_write_enable), 32'd0);
      exp_q.delete();
      wbq.delete();
      for (int i = 0; i < 64; i++) arch[i] = mem[i];
    end else begin
      check_eq("wb_ready", 32'(wb_ready), 32'(wbq.size() < WB_DEPTH));
      if (wbq.size() != 0) begin
        check_eq("wr_en", 32'(rf_write_enable), 32'd1);
        check_eq("wr_idx", 32'(rf_idx_write), 32'(wbq[0].idx));
        check_eq("wr_data", rf_reg_write, wbq[0].data);
        void'(wbq.pop_front());
      end else begin
        check_eq("wr_idle", 32'(rf_write_enable), 32'd0);
      end
      if (out_valid) begin
        check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_eq("out_a", out_a, exp_q[0].a);
          check_eq("out_b", out_b, exp_q[0].b);
          check_eq("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (op_valid && op_ready) begin
        last_accept = 1'b1;
        r.tag = op_tag;
        r.a   = arch_val(op_idx_a);
        r.b   = arch_val(op_idx_b);
        exp_q.push_back(r);
      end
      if (wb_valid && wb_ready && wb_idx != 6'd62 && wb_idx != 6'd63) begin
        w.idx  = wb_idx;
        w.data = wb_data;
        wbq.push_back(w);
        arch[wb_idx] = wb_data;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[5]  = 32'h11;
    mem[6]  = 32'h22;
    mem[62] = 32'hBAD0_0062;
    mem[63] = 32'hBAD0_0063;
    idle();
    reset = 1'b1;
    @(negedge clk);
    eval();
    eval();
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_a", out_a, 32'd0);
    check_eq("rst_out_b", out_b, 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
    check_eq("rst_we", 32'(rf_write_enable), 32'd0);
    check_eq("rst_wb_ready", 32'(wb_ready), 32'd1);

    // Basic read: result registered one cycle after the in-flight stage.
    op_valid = 1'b1; op_idx_a = 6'd5; op_idx_b = 6'd6; op_tag = 4'd3;
    #1;
    check_eq("first_op_ready", 32'(op_ready), 32'd1);
    eval();
    idle();
    check_eq("lat_early", 32'(out_valid), 32'd0);
    eval();
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("lat_a", out_a, 32'h11);
    check_eq("lat_b", out_b, 32'h22);
    check_eq("lat_tag", 32'(out_tag), 32'd3);
    eval();

    // Read right after a writeback to the same index.
    wb_valid = 1'b1; wb_idx = 6'd7; wb_data = 32'hDEAD;
    eval();
    idle();
    op_valid = 1'b1; op_idx_a = 6'd7; op_idx_b = 6'd8; op_tag = 4'd5;
    for (int k = 0; k < 8; k++) begin
      eval();
      if (last_accept) break;
    end
    check_eq("haz_accept", 32'(last_accept), 32'd1);
    idle();
    eval();
    check_eq("haz_out_a", out_a, 32'hDEAD);
    eval();

    // Read issued while the matching write drains: must bypass.
    wb_valid = 1'b1; wb_idx = 6'd9; wb_data = 32'hBEEF;
    eval();
    idle();
    op_valid = 1'b1; op_idx_a = 6'd9; op_idx_b = 6'd63; op_tag = 4'd9;
    check_eq("byp_we", 32'(rf_write_enable), 32'd1);
    eval();
    idle();
    eval();
    check_eq("byp_out_a", out_a, 32'hBEEF);
    check_eq("byp_out_b", out_b, 32'd1);
    eval();

    // Output stalled with back-to-back requests: one held, one in skid, then blocked.
    for (int t = 0; t < 4; t++) begin
      op_valid = 1'b1; op_idx_a = 6'(t + 1); op_idx_b = 6'(t + 2); op_tag = 4'(t + 10);
      out_ready = 1'b0;
      eval();
    end
    #1;
    check_eq("skid_op_ready", 32'(op_ready), 32'd0);
    check_eq("skid_out_valid", 32'(out_valid), 32'd1);
    check_eq("skid_pending", 32'(exp_q.size()), 32'd2);
    idle();
    repeat (5) eval();
    check_eq("skid_drained", 32'(exp_q.size()), 32'd0);

    // Writeback burst, a dropped constant write, then constant reads.
    for (int t = 0; t < 5; t++) begin
      wb_valid = 1'b1; wb_idx = 6'(10 + t); wb_data = 32'hC000_0000 + 32'(t);
      eval();
    end
    wb_valid = 1'b1; wb_idx = 6'd62; wb_data = 32'hFFFF_FFFF;
    eval();
    idle();
    check_eq("const_wr_dropped", 32'(rf_write_enable), 32'd0);
    op_valid = 1'b1; op_idx_a = 6'd63; op_idx_b = 6'd62; op_tag = 4'd7;
    eval();
    idle();
    repeat (3) eval();

    // Reset with a queued write and an in-flight read.
    wb_valid = 1'b1; wb_idx = 6'd20; wb_data = 32'h2020;
    op_valid = 1'b1; op_idx_a = 6'd20; op_idx_b = 6'd21; op_tag = 4'd1;
    eval();
    wb_idx = 6'd21; wb_data = 32'h2121; op_tag = 4'd2;
    reset = 1'b1;
    eval();
    reset = 1'b0;
    idle();
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_we", 32'(rf_write_enable), 32'd0);
    eval();
    check_eq("mid_rst_out_valid2", 32'(out_valid), 32'd0);
    check_eq("mid_rst_mem20", mem[20], 32'hA000_0014);
    repeat (2) eval();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      op_valid  = ($urandom_range(0, 9) < 6);
      op_idx_a  = pick_idx();
      op_idx_b  = pick_idx();
      op_tag    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 1) == 1);
      wb_idx    = pick_idx();
      wb_data   = $urandom();
      reset     = ($urandom_range(0, 199) == 0);
      eval();
    end
    reset = 1'b0;
    idle();
    repeat (10) eval();
    check_eq("final_results_empty", 32'(exp_q.size()), 32'd0);
    check_eq("final_queue_empty", 32'(wbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
